// File: rtl/cdc_handshake_tx.sv
// Transmit half of a four-phase req/ack clock-domain-crossing handshake.
// Captures one word and holds it on xfer_data while xfer_req is raised. It then waits
// for the synchronized acknowledge to rise and fall. A sticky timeout_err flags a
// remote that stalls in either ack phase.
`timescale 1ns/1ps
module cdc_handshake_tx #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2,   // must be >= 2
   parameter int unsigned ACK_TIMEOUT = 255  // 0 disables the timeout
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_ready,
   output logic                  xfer_req,
   output logic [DATA_WIDTH-1:0] xfer_data,
   input  logic                  xfer_ack,
   output logic                  done,
   output logic                  timeout_err,
   input  logic                  clear_err
);

   localparam int unsigned CntW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntLimit = CntW'(ACK_TIMEOUT);
   localparam bit TimeoutEn = (ACK_TIMEOUT > 0);

   typedef enum logic [1:0] {StIdle, StReq, StAckLo, StErr} state_e;

   state_e                  state_q, state_d;
   logic                    req_q, req_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [CntW-1:0]         cnt_inc;
   logic                    timed_out;
   logic [SYNC_STAGES-1:0]  ack_sync_q, ack_sync_d;
   logic                    ack_s;

   // xfer_ack is asynchronous; only the last stage of the chain reaches the FSM.
   assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], xfer_ack};
   assign ack_s      = ack_sync_q[SYNC_STAGES-1];

   // Saturating increment so the phase counter never wraps back under the limit.
   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign timed_out = TimeoutEn && (cnt_q == CntLimit);

   assign src_ready   = (state_q == StIdle);
   assign xfer_req    = req_q;
   assign xfer_data   = data_q;
   assign done        = done_q;
   assign timeout_err = err_q;

   // Next-state logic for the handshake FSM; an ack seen at the limit beats the timeout.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (src_valid) begin
               data_d  = src_data;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = StReq;
            end
         end
         StReq: begin
            if (ack_s) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = StAckLo;
            end else if (timed_out) begin
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = StErr;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StAckLo: begin
            if (!ack_s) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (timed_out) begin
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = StErr;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StErr: begin
            // Leave only once the remote has released ack, so the next request starts clean.
            if (clear_err && !ack_s) begin
               err_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
   end

   // FSM state, registered outputs and phase counter.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Acknowledge synchronizer chain.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ack_sync_q <= '0;
      end else begin
         ack_sync_q <= ack_sync_d;
      end
   end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: one default instance (a) and one with a
// short ack timeout (b) for the error paths.
`timescale 1ns/1ps
module tb_cdc_handshake_tx;

   localparam int unsigned S = 2;

   logic       clk;
   logic       n_rst;
   logic       src_valid, xfer_ack, clear_err;
   logic [7:0] src_data;
   logic       src_ready, xfer_req, done, timeout_err;
   logic [7:0] xfer_data;

   logic       valid_b, ack_b, clr_b;
   logic [7:0] sdata_b;
   logic       ready_b, req_b, done_b, err_b;
   logic [7:0] xdata_b;

   int errors = 0;
   int checks = 0;

   cdc_handshake_tx #(.DATA_WIDTH(8), .SYNC_STAGES(S), .ACK_TIMEOUT(255)) dut_a (
      .clk         (clk),
      .n_rst       (n_rst),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_ready   (src_ready),
      .xfer_req    (xfer_req),
      .xfer_data   (xfer_data),
      .xfer_ack    (xfer_ack),
      .done        (done),
      .timeout_err (timeout_err),
      .clear_err   (clear_err)
   );

   cdc_handshake_tx #(.DATA_WIDTH(8), .SYNC_STAGES(S), .ACK_TIMEOUT(4)) dut_b (
      .clk         (clk),
      .n_rst       (n_rst),
      .src_valid   (valid_b),
      .src_data    (sdata_b),
      .src_ready   (ready_b),
      .xfer_req    (req_b),
      .xfer_data   (xdata_b),
      .xfer_ack    (ack_b),
      .done        (done_b),
      .timeout_err (err_b),
      .clear_err   (clr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transfer on instance a, remote answers lat cycles after each req edge.
   task automatic run_xfer(input logic [7:0] d, input int lat, input bit hold);
      src_valid = 1'b1;
      src_data  = d;
      tick();
      chk("acc_req", xfer_req, 1);
      chk("acc_data", xfer_data, d);
      chk("acc_rdy", src_ready, 0);
      if (!hold) src_valid = 1'b0;
      for (int i = 0; i < lat; i++) begin
         tick();
         chk("req_wait", xfer_req, 1);
         chk("req_data", xfer_data, d);
      end
      xfer_ack = 1'b1;
      for (int i = 0; i < S; i++) begin
         tick();
         chk("req_sync", xfer_req, 1);
         chk("rdy_busy", src_ready, 0);
      end
      tick();
      chk("req_fall", xfer_req, 0);
      chk("lo_data", xfer_data, d);
      for (int i = 0; i < lat; i++) begin
         tick();
         chk("lo_req", xfer_req, 0);
         chk("lo_done", done, 0);
         chk("lo_data2", xfer_data, d);
      end
      xfer_ack = 1'b0;
      for (int i = 0; i < S; i++) begin
         tick();
         chk("done_early", done, 0);
         chk("rdy_lo", src_ready, 0);
         chk("lo_data3", xfer_data, d);
      end
      tick();
      chk("done_pulse", done, 1);
      chk("rdy_back", src_ready, 1);
      chk("done_data", xfer_data, d);
   endtask

   initial begin
      int  dcount;
      bit  seen;
      n_rst = 1'b1;
      src_valid = 1'b0; src_data = 8'h00; xfer_ack = 1'b0; clear_err = 1'b0;
      valid_b = 1'b0; sdata_b = 8'h00; ack_b = 1'b0; clr_b = 1'b0;

      // 1. Asynchronous reset mid-cycle with busy-looking inputs.
      #2;
      n_rst = 1'b0;
      src_valid = 1'b1; src_data = 8'hA5; xfer_ack = 1'b1;
      #1;
      chk("rst_req", xfer_req, 0);
      chk("rst_data", xfer_data, 8'h00);
      chk("rst_err", timeout_err, 0);
      chk("rst_rdy", src_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_rdy_b", ready_b, 1);
      tick();
      tick();
      chk("rst_hold_req", xfer_req, 0);
      chk("rst_hold_data", xfer_data, 8'h00);
      src_valid = 1'b0; xfer_ack = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_req", xfer_req, 0);
         chk("post_rst_rdy", src_ready, 1);
         chk("post_rst_err_b", err_b, 0);
      end

      // 2. Normal transfer, 3-cycle remote; valid dropped after accept.
      run_xfer(8'h3C, 3, 1'b0);
      tick();
      chk("t2_done_once", done, 0);
      chk("t2_idle_req", xfer_req, 0);

      // 3. Back-to-back words with valid held; minimum-latency remote.
      run_xfer(8'h01, 0, 1'b1);
      run_xfer(8'h02, 0, 1'b1);
      run_xfer(8'h03, 1, 1'b1);
      src_valid = 1'b0;
      tick();
      chk("t3_idle_rdy", src_ready, 1);
      chk("t3_idle_req", xfer_req, 0);
      chk("t3_no_done", done, 0);
      chk("t3_last_data", xfer_data, 8'h03);

      // 4. Ack timeout on instance b (limit 4), ack held low.
      valid_b = 1'b1; sdata_b = 8'h77;
      tick();
      chk("t4_req", req_b, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_no_err", err_b, 0);
         chk("t4_req_hold", req_b, 1);
      end
      tick();
      chk("t4_err", err_b, 1);
      chk("t4_req_drop", req_b, 0);
      chk("t4_rdy", ready_b, 0);
      sdata_b = 8'h11;
      tick();
      tick();
      chk("t4_err_sticky", err_b, 1);
      chk("t4_valid_ign", req_b, 0);
      chk("t4_data_hold", xdata_b, 8'h77);
      clr_b = 1'b1;
      tick();
      chk("t4_clr_err", err_b, 0);
      chk("t4_clr_rdy", ready_b, 1);
      clr_b = 1'b0; valid_b = 1'b0;
      tick();
      chk("t4_idle_req", req_b, 0);

      // 5. Stuck ack while in ERR.
      valid_b = 1'b1; sdata_b = 8'h88;
      tick();
      valid_b = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("t5_err", err_b, 1);
      ack_b = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      clr_b = 1'b1;
      tick();
      chk("t5_stuck_err", err_b, 1);
      chk("t5_stuck_rdy", ready_b, 0);
      ack_b = 1'b0;
      tick();
      chk("t5_sync1_err", err_b, 1);
      tick();
      chk("t5_sync2_err", err_b, 1);
      tick();
      chk("t5_exit_err", err_b, 0);
      chk("t5_exit_rdy", ready_b, 1);
      clr_b = 1'b0;

      // 6. ack_s rises exactly when the counter reaches the limit.
      valid_b = 1'b1; sdata_b = 8'h99;
      tick();
      valid_b = 1'b0;
      tick();
      tick();
      ack_b = 1'b1;
      tick();
      tick();
      chk("t6_pre_req", req_b, 1);
      tick();
      chk("t6_no_err", err_b, 0);
      chk("t6_acklo_req", req_b, 0);
      chk("t6_acklo_rdy", ready_b, 0);
      ack_b = 1'b0;
      tick();
      tick();
      chk("t6_no_done_yet", done_b, 0);
      tick();
      chk("t6_done", done_b, 1);
      chk("t6_err_clean", err_b, 0);

      // 7. Ack edges placed right around the active clock edge.
      src_valid = 1'b1; src_data = 8'h5A;
      tick();
      src_valid = 1'b0;
      #8.905;
      xfer_ack = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         chk("t7_req_known", {31'd0, $isunknown(xfer_req)}, 0);
         if (xfer_req === 1'b0) seen = 1'b1;
      end
      chk("t7_req_fell", {31'd0, seen}, 1);
      @(posedge clk);
      #0.05;
      xfer_ack = 1'b0;
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t7_done_known", {31'd0, $isunknown(done)}, 0);
         if (done === 1'b1) dcount++;
      end
      chk("t7_done_count", dcount, 1);
      chk("t7_rdy", src_ready, 1);

      // Reset asserted mid-transfer drops xfer_req without waiting for an edge.
      src_valid = 1'b1; src_data = 8'hC3;
      tick();
      src_valid = 1'b0;
      chk("mid_req", xfer_req, 1);
      tick();
      #3;
      n_rst = 1'b0;
      #1;
      chk("mid_rst_req", xfer_req, 0);
      chk("mid_rst_data", xfer_data, 8'h00);
      chk("mid_rst_rdy", src_ready, 1);
      @(negedge clk);
      n_rst = 1'b1;
      tick();
      chk("mid_post_req", xfer_req, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
